// File: rtl/qsys_led_pkg.sv
// qsys_led_pkg: shared mode codes, FSM states and PIO register map for the LED sequencer
//   MODE_*       : pattern advance rule selected by the mode input
//   state_e      : bus FSM states
//   PIO_DATA_OFS : word offset of the PIO data register
package qsys_led_pkg;
   typedef enum logic [1:0] {
      MODE_WALK   = 2'd0,
      MODE_BOUNCE = 2'd1,
      MODE_COUNT  = 2'd2,
      MODE_HOLD   = 2'd3
   } mode_e;
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WR,
      ST_RD
   } state_e;
   localparam int unsigned PIO_DATA_OFS = 0;
endpackage

// File: rtl/qsys_led_sequencer_if.sv
// qsys_led_sequencer_if: Avalon-MM initiator/target signal bundle for the PIO data port
//   address, chipselect, write_n, read_n, writedata : initiator -> target
//   readdata, waitrequest                            : target -> initiator
interface qsys_led_sequencer_if #(parameter int ADDR_W = 2);
   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              write_n;
   logic              read_n;
   logic [31:0]       writedata;
   logic [31:0]       readdata;
   logic              waitrequest;
   modport master (output address, chipselect, write_n, read_n, writedata, input readdata, waitrequest);
   modport slave (input address, chipselect, write_n, read_n, writedata, output readdata, waitrequest);
endinterface

// File: rtl/qsys_led_tick_gen.sv
// qsys_led_tick_gen: free-running divider producing a one-cycle tick every TICK_DIV clocks
//   clk, reset_n : clock, synchronous active-low reset
//   i_enable     : 1 runs the counter, 0 holds it at zero
//   o_tick       : high for the cycle in which the count sits at TICK_DIV-1
module qsys_led_tick_gen #(
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_enable,
   output logic o_tick
);
   localparam int unsigned CW = $clog2(TICK_DIV);
   logic [CW-1:0] r_cnt;
   logic          w_tc;
   assign w_tc   = r_cnt == CW'(TICK_DIV - 1);
   assign o_tick = i_enable && w_tc;
   always_ff @(posedge clk)
      if (!reset_n || !i_enable) r_cnt <= '0;
      else r_cnt <= w_tc ? '0 : r_cnt + CW'(1);
endmodule

// File: rtl/qsys_led_sequencer.sv
// qsys_led_sequencer: Avalon-MM initiator writing a timed LED pattern to a PIO, with optional read-back check
//   clk, reset_n  : clock, synchronous active-low reset
//   i_enable      : runs the tick divider
//   i_mode        : 0 walk, 1 bounce, 2 count, 3 hold
//   i_clear_err   : clears o_mismatch and o_overrun (wins over a same-cycle set)
//   bus           : Avalon-MM initiator port to the PIO data register
//   o_pattern     : value the next write will carry
//   o_busy        : a transfer is in progress
//   o_mismatch    : sticky read-back error
//   o_overrun     : sticky dropped-tick flag
module qsys_led_sequencer
   import qsys_led_pkg::*;
#(
   parameter int          DATA_W   = 10,
   parameter int          ADDR_W   = 2,
   parameter int unsigned TICK_DIV = 50_000_000,
   parameter bit          VERIFY   = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_enable,
   input  logic [1:0]            i_mode,
   input  logic                  i_clear_err,
   qsys_led_sequencer_if.master  bus,
   output logic [DATA_W-1:0]     o_pattern,
   output logic                  o_busy,
   output logic                  o_mismatch,
   output logic                  o_overrun
);
   state_e              r_state;
   logic                r_pending;
   logic                r_dir;
   logic [DATA_W-1:0]   r_shadow;
   logic                w_tick;
   logic                w_onehot;
   logic                w_eff_right;
   logic [DATA_W-1:0]   w_shift;
   logic [DATA_W-1:0]   w_pat_nxt;
   logic                w_dir_nxt;
   logic                w_mm_set;
   logic                w_unused_rd;
   qsys_led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_enable (i_enable),
      .o_tick   (w_tick)
   );
   assign o_busy      = r_state != ST_IDLE;
   assign w_unused_rd = ^bus.readdata[31:DATA_W];
   assign w_mm_set    = (r_state == ST_RD) && !bus.waitrequest && (bus.readdata[DATA_W-1:0] != r_shadow);
   // r_dir: 1 = shifting right. An end bit forces the direction so a stale
   // dir left over from another mode can never shift the lit bit out.
   always_comb begin
      w_onehot    = (o_pattern != '0) && ((o_pattern & (o_pattern - DATA_W'(1))) == '0);
      w_eff_right = o_pattern[DATA_W-1] || (r_dir && !o_pattern[0]);
      w_shift     = w_eff_right ? o_pattern >> 1 : o_pattern << 1;
      w_pat_nxt   = o_pattern;
      w_dir_nxt   = r_dir;
      case (mode_e'(i_mode))
         MODE_WALK: begin
            w_pat_nxt = w_onehot ? {o_pattern[DATA_W-2:0], o_pattern[DATA_W-1]} : DATA_W'(1);
            w_dir_nxt = w_onehot && r_dir;
         end
         MODE_BOUNCE: begin
            w_pat_nxt = w_onehot ? w_shift : DATA_W'(1);
            w_dir_nxt = !w_onehot ? 1'b0 : w_shift[DATA_W-1] ? 1'b1 : w_shift[0] ? 1'b0 : w_eff_right;
         end
         MODE_COUNT: w_pat_nxt = o_pattern + DATA_W'(1);
         default: w_pat_nxt = o_pattern;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state        <= ST_IDLE;
         bus.chipselect <= 1'b0;
         bus.write_n    <= 1'b1;
         bus.read_n     <= 1'b1;
         bus.address    <= '0;
         bus.writedata  <= '0;
         o_pattern      <= DATA_W'(1);
         r_dir          <= 1'b0;
         r_shadow       <= '0;
         r_pending      <= 1'b0;
         o_mismatch     <= 1'b0;
         o_overrun      <= 1'b0;
      end else begin
         // One-deep tick queue: only fills while a transfer is running,
         // and is always drained by the IDLE state.
         r_pending   <= o_busy && (r_pending || w_tick);
         o_overrun   <= !i_clear_err && (o_overrun || (w_tick && r_pending));
         o_mismatch  <= !i_clear_err && (o_mismatch || w_mm_set);
         bus.address <= ADDR_W'(PIO_DATA_OFS);
         case (r_state)
            ST_IDLE:
               if (w_tick || r_pending) begin
                  r_state        <= ST_WR;
                  bus.chipselect <= 1'b1;
                  bus.write_n    <= 1'b0;
                  bus.writedata  <= 32'(o_pattern);
               end
            ST_WR:
               if (!bus.waitrequest) begin
                  r_shadow       <= o_pattern;
                  o_pattern      <= w_pat_nxt;
                  r_dir          <= w_dir_nxt;
                  bus.write_n    <= 1'b1;
                  bus.read_n     <= !VERIFY;
                  bus.chipselect <= VERIFY;
                  r_state        <= VERIFY ? ST_RD : ST_IDLE;
               end
            ST_RD:
               if (!bus.waitrequest) begin
                  bus.read_n     <= 1'b1;
                  bus.chipselect <= 1'b0;
                  r_state        <= ST_IDLE;
               end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_qsys_led_sequencer.sv
// tb_qsys_led_sequencer: directed plus randomized bench with a PIO target model and pattern reference model
module tb_qsys_led_sequencer;
   localparam int DW = 10;
   localparam int TD = 4;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic enable = 1'b0;
   logic clear_err = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [DW-1:0] pattern;
   logic busy, mismatch, overrun;
   logic wreq = 1'b0;
   logic corrupt = 1'b0;
   logic wr_rand = 1'b0;
   logic [DW-1:0] pio = '0;
   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   int mp = 1;
   bit mdir = 1'b0;
   bit saw_wrap = 1'b0;
   int prev_wd = -1;
   logic [31:0] wd;
   int c0;
   qsys_led_sequencer_if #(.ADDR_W(2)) bus ();
   assign bus.waitrequest = wreq;
   assign bus.readdata    = corrupt ? 32'd0 : 32'(pio);
   qsys_led_sequencer #(.DATA_W(DW), .ADDR_W(2), .TICK_DIV(TD), .VERIFY(1'b1)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_enable    (enable),
      .i_mode      (mode),
      .i_clear_err (clear_err),
      .bus         (bus),
      .o_pattern   (pattern),
      .o_busy      (busy),
      .o_mismatch  (mismatch),
      .o_overrun   (overrun)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   function automatic int onehot_pos(input int v);
      int pos = -1;
      int cnt = 0;
      for (int i = 0; i < DW; i++) if (v[i]) begin pos = i; cnt++; end
      return (cnt == 1) ? pos : -1;
   endfunction
   // Reference: the lit LED is a position on a 10-slot strip
   task automatic model_adv(input int m);
      int p = onehot_pos(mp);
      case (m)
         0: if (p < 0) begin mp = 1; mdir = 0; end else mp = (p == DW - 1) ? 1 : mp * 2;
         1: if (p < 0) begin mp = 1; mdir = 0; end else begin
               if (p == DW - 1) mdir = 1; else if (p == 0) mdir = 0;
               p = mdir ? p - 1 : p + 1;
               if (p == DW - 1) mdir = 1; else if (p == 0) mdir = 0;
               mp = 1 << p;
            end
         2: mp = (mp + 1) % (1 << DW);
         default: ;
      endcase
   endtask
   task automatic wait_for(input int kind, input string tag);
      bit hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clk);
         hit = (kind == 0) ? (bus.chipselect && !bus.write_n) : (bus.chipselect && !bus.read_n);
      end
      chk(tag, 32'(hit), 32'd1);
   endtask
   task automatic wait_idle(input string tag);
      bit hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clk);
         hit = !busy;
      end
      chk(tag, 32'(hit), 32'd1);
   endtask
   task automatic wait_writes(input int n, input string tag);
      int target = wr_cnt + n;
      for (int i = 0; i < 20 * n + 100 && wr_cnt < target; i++) @(negedge clk);
      chk(tag, 32'(wr_cnt >= target), 32'd1);
   endtask
   task automatic pulse_clear();
      step();
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
   endtask
   // Write monitor + PIO target: every accepted write is checked against the model
   initial forever begin
      @(negedge clk);
      if (!reset_n) begin
         mp = 1;
         mdir = 0;
      end else if (bus.chipselect && !bus.write_n && !wreq) begin
         chk("wr_data", bus.writedata, 32'(mp));
         if (prev_wd == 1023 && bus.writedata == 32'd0) saw_wrap = 1'b1;
         prev_wd = int'(bus.writedata);
         pio = bus.writedata[DW-1:0];
         wr_cnt++;
         model_adv(int'(mode));
      end
   end
   initial forever begin
      step();
      if (wr_rand) wreq = 1'($urandom_range(0, 1));
   end
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
   initial begin
      reset_n = 1'b0;
      enable = 1'b1;
      mode = 2'd0;
      repeat (3) step();
      @(negedge clk);
      chk("rst_cs", bus.chipselect, 0);
      chk("rst_write_n", bus.write_n, 1);
      chk("rst_read_n", bus.read_n, 1);
      chk("rst_addr", bus.address, 0);
      chk("rst_wdata", bus.writedata, 0);
      chk("rst_pattern", pattern, 1);
      chk("rst_busy", busy, 0);
      chk("rst_mismatch", mismatch, 0);
      chk("rst_overrun", overrun, 0);
      step();
      reset_n = 1'b1;
      // First tick after TICK_DIV counts; write, read, idle, then the next tick
      for (int n = 0; n <= 8; n++) begin
         @(negedge clk);
         chk($sformatf("lat_wr_%0d", n), !bus.write_n, n == 4 || n == 8);
         chk($sformatf("lat_rd_%0d", n), !bus.read_n, n == 5);
         chk($sformatf("lat_busy_%0d", n), busy, n == 4 || n == 5 || n == 8);
         if (n == 4) chk("first_wdata", bus.writedata, 32'h001);
      end
      wait_writes(12, "walk_run");
      chk("walk_mismatch", mismatch, 0);
      step();
      mode = 2'd1;
      wait_writes(25, "bounce_run");
      chk("bounce_mismatch", mismatch, 0);
      step();
      mode = 2'd2;
      wait_writes(1030, "count_run");
      chk("count_wrap", 32'(saw_wrap), 1);
      // Stall a write for several cycles
      wait_idle("stall_idle");
      step();
      mode = 2'd3;
      wreq = 1'b1;
      wait_for(0, "stall_wr");
      wd = bus.writedata;
      c0 = wr_cnt;
      repeat (3) begin
         @(negedge clk);
         chk("stall_wdata", bus.writedata, wd);
         chk("stall_write_n", bus.write_n, 0);
         chk("stall_cs", bus.chipselect, 1);
      end
      step();
      wreq = 1'b0;
      wait_for(1, "stall_rd");
      chk("stall_one_write", wr_cnt, c0 + 1);
      // Read-back corruption sets a sticky mismatch
      step();
      mode = 2'd0;
      wait_writes(2, "pre_mm");
      step();
      corrupt = 1'b1;
      wait_for(1, "mm_rd");
      @(negedge clk);
      chk("mm_set", mismatch, 1);
      step();
      corrupt = 1'b0;
      wait_writes(2, "mm_sticky_run");
      chk("mm_sticky", mismatch, 1);
      pulse_clear();
      @(negedge clk);
      chk("mm_clear", mismatch, 0);
      // Long stall: pending then overrun; one queued write survives enable=0
      wait_idle("ovr_idle");
      pulse_clear();
      @(negedge clk);
      chk("ovr_pre", overrun, 0);
      step();
      mode = 2'd3;
      wreq = 1'b1;
      wait_for(0, "ovr_wr");
      repeat (3 * TD) @(negedge clk);
      chk("ovr_set", overrun, 1);
      chk("ovr_busy", busy, 1);
      c0 = wr_cnt;
      step();
      enable = 1'b0;
      wreq = 1'b0;
      repeat (20) @(negedge clk);
      chk("ovr_writes", wr_cnt, c0 + 2);
      chk("ovr_sticky", overrun, 1);
      chk("ovr_idle_after", busy, 0);
      pulse_clear();
      @(negedge clk);
      chk("ovr_clear", overrun, 0);
      // Reset while the read is on the bus
      step();
      enable = 1'b1;
      mode = 2'd0;
      wait_for(0, "rst_wr");
      step();
      reset_n = 1'b0;
      @(negedge clk);
      chk("rst_in_rd", bus.read_n, 0);
      @(negedge clk);
      chk("rstrd_cs", bus.chipselect, 0);
      chk("rstrd_read_n", bus.read_n, 1);
      chk("rstrd_write_n", bus.write_n, 1);
      chk("rstrd_pattern", pattern, 1);
      chk("rstrd_busy", busy, 0);
      step();
      reset_n = 1'b1;
      // Randomized modes, enable and waitrequest
      c0 = wr_cnt;
      wr_rand = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         step();
         if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
         enable = ($urandom_range(0, 7) != 0);
      end
      wr_rand = 1'b0;
      step();
      step();
      wreq = 1'b0;
      repeat (20) @(negedge clk);
      chk("rand_mismatch", mismatch, 0);
      chk("rand_progress", 32'(wr_cnt > c0 + 50), 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
